// File: rtl/udp_arb_pkg.sv
// Shared types and constants for the UDP command arbiter: FSM encoding,
// payload framing constants and the source/command byte packer.
package udp_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    REQ,
    SEND,
    DRAIN,
    DONE
  } arb_state_t;

  localparam logic [7:0]  HEADER_DEFAULT = 8'hA5;
  localparam logic [15:0] PAYLOAD_LEN    = 16'd2;
  localparam int unsigned ID_W           = 4;

  function automatic logic [7:0] payload_byte(input logic [ID_W-1:0] id,
                                              input logic [1:0]      cmd);
    return {2'b00, id, cmd};
  endfunction

endpackage

// File: rtl/udp_rr_picker.sv
// Combinational round-robin picker: first pending requester strictly after
// last_grant, wrapping modulo NUM_REQ.
module udp_rr_picker
  import udp_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_pending
);

  logic            hi_found;
  logic            lo_found;
  logic [ID_W-1:0] hi_id;
  logic [ID_W-1:0] lo_id;

  // Lowest pending index above last_grant wins; otherwise wrap to the lowest at or below it.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pending[i]) begin
        if (ID_W'(i) > last_grant) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_id    = ID_W'(i);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_id    = ID_W'(i);
        end
      end
    end
  end

  assign grant_id    = hi_found ? hi_id : lo_id;
  assign any_pending = |pending;

endmodule

// File: rtl/udp_cmd_arbiter.sv
// Round-robin arbiter framing 2-bit commands as 2-byte UDP payloads.
// Define UDP_ARB_TIMEOUT_EN to abandon a request after ACK_TIMEOUT cycles without ack.
module udp_cmd_arbiter
  import udp_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ACK_TIMEOUT = 50000,
  parameter logic [7:0]  HEADER      = HEADER_DEFAULT
) (
  input  logic                 clk_50,
  input  logic                 sys_rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_cmd,
  output logic [NUM_REQ-1:0]   req_busy,
  output logic [NUM_REQ-1:0]   req_done,
  output logic [NUM_REQ-1:0]   req_drop,
  output logic                 tx_error,
  input  logic                 udp_tx_ready,
  input  logic                 app_tx_ack,
  output logic                 app_tx_data_request,
  output logic                 app_tx_data_valid,
  output logic [7:0]           app_tx_data,
  output logic [15:0]          udp_data_length
);

  if (NUM_REQ < 2 || NUM_REQ > 16 || ACK_TIMEOUT < 1) begin : g_bad_cfg
    $error("udp_cmd_arbiter: NUM_REQ must be 2..16 and ACK_TIMEOUT nonzero");
  end

  arb_state_t                state;
  arb_state_t                state_n;
  logic [NUM_REQ-1:0]        pending;
  logic [NUM_REQ-1:0]        accept;
  logic [NUM_REQ-1:0]        grant_vec;
  logic [NUM_REQ-1:0]        release_vec;
  logic [NUM_REQ-1:0][1:0]   cmd_q;
  logic [ID_W-1:0]           grant_id;
  logic [ID_W-1:0]           last_grant;
  logic [ID_W-1:0]           pick_id;
  logic [1:0]                grant_cmd;
  logic                      any_pending;
  logic                      load_grant;
  logic                      release_slot;
  logic                      timeout_hit;
  logic                      drain_armed;
  logic                      request_n;
  logic                      valid_n;
  logic [7:0]                data_n;

  udp_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .pending     (pending),
    .last_grant  (last_grant),
    .grant_id    (pick_id),
    .any_pending (any_pending)
  );

  always_comb begin
    grant_vec = '0;
    grant_cmd = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        grant_vec[i] = 1'b1;
        grant_cmd    = cmd_q[i];
      end
    end
  end

  assign release_vec = release_slot ? grant_vec : '0;
  // A slot being released this cycle may be refilled by a same-cycle strobe.
  assign accept      = req_valid & (~pending | release_vec);

  always_ff @(posedge clk_50 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pending  <= '0;
      cmd_q    <= '0;
      req_drop <= '0;
    end else begin
      pending  <= (pending & ~release_vec) | accept;
      req_drop <= req_valid & ~accept;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) cmd_q[i] <= req_cmd[2*i +: 2];
      end
    end
  end

  assign req_busy        = pending;
  assign req_done        = (state == DONE) ? grant_vec : '0;
  assign udp_data_length = PAYLOAD_LEN;

`ifdef UDP_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = ($clog2(ACK_TIMEOUT + 1) > 16) ? $clog2(ACK_TIMEOUT + 1) : 16;
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk_50 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      to_cnt   <= '0;
      tx_error <= 1'b0;
    end else begin
      to_cnt   <= (state == REQ) ? to_cnt + 1'b1 : '0;
      tx_error <= timeout_hit;
    end
  end

  assign timeout_hit = (state == REQ) && !app_tx_ack && (to_cnt == TO_W'(ACK_TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
  assign tx_error    = 1'b0;
`endif

  always_comb begin
    state_n      = state;
    request_n    = 1'b0;
    valid_n      = 1'b0;
    data_n       = '0;
    load_grant   = 1'b0;
    release_slot = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_pending) begin
          load_grant = 1'b1;
          state_n    = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (udp_tx_ready) begin
          request_n = 1'b1;
          state_n   = REQ;
        end
      end
      REQ: begin
        if (app_tx_ack) begin
          valid_n = 1'b1;
          data_n  = HEADER;
          state_n = SEND;
        end else if (timeout_hit) begin
          release_slot = 1'b1;
          state_n      = IDLE;
        end else begin
          request_n = 1'b1;
        end
      end
      SEND: begin
        valid_n = 1'b1;
        data_n  = payload_byte(grant_id, grant_cmd);
        state_n = DRAIN;
      end
      DRAIN: begin
        if (drain_armed && udp_tx_ready) state_n = DONE;
      end
      DONE: begin
        release_slot = 1'b1;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Payload outputs are registered so each byte appears the cycle after its decision.
  always_ff @(posedge clk_50 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state               <= IDLE;
      grant_id            <= '0;
      last_grant          <= ID_W'(NUM_REQ - 1);
      drain_armed         <= 1'b0;
      app_tx_data_request <= 1'b0;
      app_tx_data_valid   <= 1'b0;
      app_tx_data         <= '0;
    end else begin
      state               <= state_n;
      drain_armed         <= (state == DRAIN);
      app_tx_data_request <= request_n;
      app_tx_data_valid   <= valid_n;
      app_tx_data         <= data_n;
      if (load_grant)   grant_id   <= pick_id;
      if (release_slot) last_grant <= grant_id;
    end
  end

endmodule

// File: tb/tb_udp_cmd_arbiter.sv
// Scoreboard bench for udp_cmd_arbiter: stimulus pushes expected payload bytes
// and completion vectors; a negedge monitor pops and compares them.
module tb_udp_cmd_arbiter;

  typedef struct packed {
    logic [7:0] data;
    logic       hdr;
  } exp_byte_t;

  logic        clk_50 = 1'b0;
  logic        sys_rst_n;
  logic [3:0]  req_valid;
  logic [7:0]  req_cmd;
  logic [3:0]  req_busy;
  logic [3:0]  req_done;
  logic [3:0]  req_drop;
  logic        tx_error;
  logic        udp_tx_ready;
  logic        app_tx_ack;
  logic        app_tx_data_request;
  logic        app_tx_data_valid;
  logic [7:0]  app_tx_data;
  logic [15:0] udp_data_length;

  exp_byte_t   exp_bytes[$];
  logic [3:0]  exp_done[$];
  exp_byte_t   mon_e;
  logic [3:0]  mon_d;
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int unsigned ack_cyc = 0;
  logic        prev_valid = 1'b0;
  logic        ack_en = 1'b1;
  int unsigned ack_delay = 3;

  udp_cmd_arbiter #(
    .NUM_REQ     (4),
    .ACK_TIMEOUT (20),
    .HEADER      (8'hA5)
  ) dut (
    .clk_50              (clk_50),
    .sys_rst_n           (sys_rst_n),
    .req_valid           (req_valid),
    .req_cmd             (req_cmd),
    .req_busy            (req_busy),
    .req_done            (req_done),
    .req_drop            (req_drop),
    .tx_error            (tx_error),
    .udp_tx_ready        (udp_tx_ready),
    .app_tx_ack          (app_tx_ack),
    .app_tx_data_request (app_tx_data_request),
    .app_tx_data_valid   (app_tx_data_valid),
    .app_tx_data         (app_tx_data),
    .udp_data_length     (udp_data_length)
  );

  initial forever #10 clk_50 = ~clk_50;

  always @(posedge clk_50) begin
    if (app_tx_ack) ack_cyc = cyc;
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  task automatic exp_frame(input logic [3:0] done_vec, input logic [7:0] second);
    exp_bytes.push_back('{data: 8'hA5, hdr: 1'b1});
    exp_bytes.push_back('{data: second, hdr: 1'b0});
    exp_done.push_back(done_vec);
  endtask

  // UDP core model: acks ack_delay cycles into a request, for one cycle.
  initial begin
    int unsigned rc;
    rc = 0;
    app_tx_ack = 1'b0;
    forever begin
      @(negedge clk_50);
      if (app_tx_ack) app_tx_ack = 1'b0;
      else if (app_tx_data_request && ack_en) begin
        rc++;
        if (rc >= ack_delay) begin
          app_tx_ack = 1'b1;
          rc = 0;
        end
      end else rc = 0;
    end
  end

  always @(negedge clk_50) begin
    if (app_tx_data_valid) begin
      if (exp_bytes.size() == 0) fail("unexpected_byte", {24'd0, app_tx_data});
      else begin
        mon_e = exp_bytes.pop_front();
        check("payload_byte", {24'd0, app_tx_data}, {24'd0, mon_e.data});
        if (mon_e.hdr) check("hdr_after_ack", cyc - ack_cyc, 1);
        else           check("bytes_back_to_back", {31'd0, prev_valid}, 1);
      end
    end
    if (req_done != 4'b0000) begin
      if (exp_done.size() == 0) fail("unexpected_done", {28'd0, req_done});
      else begin
        mon_d = exp_done.pop_front();
        check("done_vec", {28'd0, req_done}, {28'd0, mon_d});
        check("done_latency_ge4", {31'd0, (cyc - ack_cyc) >= 4}, 1);
      end
    end
    prev_valid = app_tx_data_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic apply_reset();
    @(negedge clk_50);
    sys_rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk_50);
    sys_rst_n = 1'b1;
    @(negedge clk_50);
  endtask

  task automatic wait_idle(input string name);
    int unsigned n;
    n = 0;
    while ((req_busy != 0 || app_tx_data_request || app_tx_data_valid ||
            exp_bytes.size() != 0 || exp_done.size() != 0) && n < 500) begin
      @(negedge clk_50);
      n++;
    end
    check(name, {31'd0, n < 500}, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_request"}, {31'd0, app_tx_data_request}, 0);
    check({tag, "_valid"},   {31'd0, app_tx_data_valid}, 0);
    check({tag, "_data"},    {24'd0, app_tx_data}, 0);
    check({tag, "_busy"},    {28'd0, req_busy}, 0);
    check({tag, "_done"},    {28'd0, req_done}, 0);
    check({tag, "_drop"},    {28'd0, req_drop}, 0);
    check({tag, "_error"},   {31'd0, tx_error}, 0);
    check({tag, "_length"},  {16'd0, udp_data_length}, 2);
  endtask

  initial begin
    int unsigned n;
    logic        stayed_low;
    sys_rst_n    = 1'b0;
    req_valid    = '0;
    req_cmd      = '0;
    udp_tx_ready = 1'b1;
    repeat (3) @(negedge clk_50);
    check_reset_outputs("rst");
    sys_rst_n = 1'b1;
    @(negedge clk_50);

    // Single frame: req 2, cmd 3 -> A5, 0B
    exp_frame(4'b0100, 8'h0B);
    req_valid = 4'b0100;
    req_cmd   = 8'b00_11_00_00;
    @(negedge clk_50);
    req_valid = '0;
    check("single_busy", {28'd0, req_busy}, 4'b0100);
    check("single_req_e0", {31'd0, app_tx_data_request}, 0);
    @(negedge clk_50);
    check("single_req_e1", {31'd0, app_tx_data_request}, 0);
    @(negedge clk_50);
    check("single_req_e2", {31'd0, app_tx_data_request}, 1);
    wait_idle("single_idle");
    check("single_busy_fall", {28'd0, req_busy}, 0);

    // Round-robin from reset: all four at once
    apply_reset();
    exp_frame(4'b0001, 8'h00);
    exp_frame(4'b0010, 8'h05);
    exp_frame(4'b0100, 8'h0A);
    exp_frame(4'b1000, 8'h0F);
    req_valid = 4'b1111;
    req_cmd   = 8'b11_10_01_00;
    @(negedge clk_50);
    req_valid = '0;
    check("rr_busy_all", {28'd0, req_busy}, 4'b1111);
    wait_idle("rr_idle");

    // Drop: req 1 strobes again while pending; cmd 2 is kept -> 06
    exp_frame(4'b0010, 8'h06);
    req_valid = 4'b0010;
    req_cmd   = 8'b00_00_10_00;
    @(negedge clk_50);
    req_cmd   = 8'b00_00_01_00;
    @(negedge clk_50);
    req_valid = '0;
    check("drop_pulse", {28'd0, req_drop}, 4'b0010);
    @(negedge clk_50);
    check("drop_pulse_end", {28'd0, req_drop}, 0);

    // Strobe during req_done of the same requester is accepted -> 07
    n = 0;
    while (!req_done[1] && n < 200) begin
      @(negedge clk_50);
      n++;
    end
    check("done1_seen", {31'd0, n < 200}, 1);
    req_valid = 4'b0010;
    req_cmd   = 8'b00_00_11_00;
    exp_frame(4'b0010, 8'h07);
    @(negedge clk_50);
    req_valid = '0;
    check("refill_no_drop", {28'd0, req_drop}, 0);
    check("refill_busy", {28'd0, req_busy}, 4'b0010);
    wait_idle("refill_idle");

    // Ready gating: request held off for 100 cycles
    udp_tx_ready = 1'b0;
    exp_frame(4'b1000, 8'h0D);
    req_valid = 4'b1000;
    req_cmd   = 8'b01_00_00_00;
    @(negedge clk_50);
    req_valid  = '0;
    stayed_low = 1'b1;
    repeat (100) begin
      @(negedge clk_50);
      if (app_tx_data_request) stayed_low = 1'b0;
    end
    check("gate_req_low", {31'd0, stayed_low}, 1);
    udp_tx_ready = 1'b1;
    @(negedge clk_50);
    check("gate_req_rise", {31'd0, app_tx_data_request}, 1);
    wait_idle("gate_idle");

`ifdef UDP_ARB_TIMEOUT_EN
    // Ack timeout on req 0, then req 1 served (cmd 2 -> 06)
    apply_reset();
    ack_en = 1'b0;
    exp_frame(4'b0010, 8'h06);
    req_valid = 4'b0011;
    req_cmd   = 8'b00_00_10_01;
    @(negedge clk_50);
    req_valid = '0;
    n = 0;
    while (!app_tx_data_request && n < 50) begin
      @(negedge clk_50);
      n++;
    end
    check("to_req_seen", {31'd0, n < 50}, 1);
    n = 0;
    while (app_tx_data_request && n < 100) begin
      @(negedge clk_50);
      n++;
    end
    check("to_req_cycles", n, 20);
    check("to_error", {31'd0, tx_error}, 1);
    check("to_busy", {28'd0, req_busy}, 4'b0010);
    @(negedge clk_50);
    check("to_error_end", {31'd0, tx_error}, 0);
    ack_en = 1'b1;
    wait_idle("to_idle");
`endif

    // Reset while the header is on the bus: frame and queue abandoned
    apply_reset();
    exp_bytes.push_back('{data: 8'hA5, hdr: 1'b1});
    req_valid = 4'b0101;
    req_cmd   = 8'b00_01_00_10;
    @(negedge clk_50);
    req_valid = '0;
    n = 0;
    while (!app_tx_data_valid && n < 50) begin
      @(negedge clk_50);
      n++;
    end
    check("rstmid_hdr_seen", {31'd0, n < 50}, 1);
    #5 sys_rst_n = 1'b0;
    @(negedge clk_50);
    check_reset_outputs("rstmid");
    sys_rst_n = 1'b1;
    repeat (30) @(negedge clk_50);
    check("rstmid_busy_after", {28'd0, req_busy}, 0);
    check("rstmid_req_after", {31'd0, app_tx_data_request}, 0);
    check("rstmid_sb_empty", exp_bytes.size() + exp_done.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
